// File: rtl/ctx_pkg.sv
// Shared opcode encoding and context-update function for the multi-channel CTX datapath.
package ctx_pkg;

    typedef enum logic [1:0] {
        CTX_LOAD = 2'd0,
        CTX_ADD  = 2'd1,
        CTX_XOR  = 2'd2,
        CTX_READ = 2'd3
    } ctx_op_e;

    // Callers zero-extend into this width and truncate the result back to DATA_W;
    // ADD then wraps modulo 2^DATA_W after truncation.
    localparam int CTX_MAX_W = 64;

    function automatic logic [CTX_MAX_W-1:0] ctx_apply(
        input ctx_op_e                op,
        input logic [CTX_MAX_W-1:0]   cur,
        input logic [CTX_MAX_W-1:0]   data
    );
        logic [CTX_MAX_W-1:0] res;
        case (op)
            CTX_LOAD: res = data;
            CTX_ADD:  res = cur + data;
            CTX_XOR:  res = cur ^ data;
            default:  res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctx_sync_fifo.sv
// Synchronous FIFO with a registered head entry, so dout is valid one cycle after a push into an empty FIFO.
module ctx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = head_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        head_d   = head_q;
        // The next head is either the entry being written right now or one already in memory;
        // when the FIFO goes empty the old head is kept so dout never turns X.
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = din;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/ctx_mc.sv
// Multi-channel context datapath: per-channel context registers updated by LOAD/ADD/XOR/READ,
// with each result returned through an output FIFO.
module ctx_mc
    import ctx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [CH_W-1:0]   in_chan,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [CH_W-1:0]   out_chan,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic              err_chan
);

    logic [DATA_W-1:0]      ctx_q [NUM_CH];
    logic [DATA_W-1:0]      ctx_d [NUM_CH];
    logic                   err_q, err_d;
    logic                   accept, chan_ok;
    logic [NUM_CH-1:0]      ch_sel;
    logic [DATA_W-1:0]      cur_val, new_val;
    logic                   fifo_full, fifo_empty;
    logic [CH_W+DATA_W-1:0] fifo_dout;

    assign in_rdy  = !fifo_full;
    assign accept  = in_val && in_rdy;
    assign chan_ok = (32'(in_chan) < NUM_CH);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
        assign ch_sel[gi] = (in_chan == CH_W'(gi));
    end

    // An out-of-range channel selects nothing, so no context is touched and the result is zero.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                cur_val = ctx_q[i];
            end
        end
        new_val = chan_ok
                ? DATA_W'(ctx_apply(ctx_op_e'(in_op), CTX_MAX_W'(cur_val), CTX_MAX_W'(in_data)))
                : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ctx_d[i] = (accept && ch_sel[i]) ? new_val : ctx_q[i];
        end
        err_d = err_q || (accept && !chan_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            err_q <= err_d;
        end
    end

    ctx_sync_fifo #(
        .WIDTH (CH_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ({in_chan, new_val}),
        .pop   (out_rdy),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt),
        .dout  (fifo_dout)
    );

    assign out_val  = !fifo_empty;
    assign out_chan = fifo_dout[CH_W+DATA_W-1 -: CH_W];
    assign out_data = fifo_dout[DATA_W-1:0];
    assign err_chan = err_q;

endmodule

// File: tb/tb_ctx_mc.sv
// Bench for ctx_mc with three channels so the out-of-range channel path is reachable.
module tb_ctx_mc;

    localparam int DATA_W     = 8;
    localparam int NUM_CH     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = 2;
    localparam int CNT_W      = 3;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] d;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_val;
    logic              in_rdy;
    logic [CH_W-1:0]   in_chan;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_data;
    logic              out_val;
    logic              out_rdy;
    logic [CH_W-1:0]   out_chan;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              err_chan;

    int   n_cmp = 0;
    int   n_mis = 0;
    res_t sb_q[$];
    logic [DATA_W-1:0] model_ctx [NUM_CH];
    logic model_err;

    ctx_mc #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_chan  (in_chan),
        .in_op    (in_op),
        .in_data  (in_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_chan (out_chan),
        .out_data (out_data),
        .fifo_cnt (fifo_cnt),
        .err_chan (err_chan)
    );

    always #5 clk = ~clk;

    // One clock: scoreboard pop/push at the negedge, then return 1 time unit after the posedge.
    task automatic tick();
        res_t              exp_r;
        logic [DATA_W-1:0] nv;
        @(negedge clk);
        if (rst) begin
            sb_q.delete();
            for (int i = 0; i < NUM_CH; i++) model_ctx[i] = '0;
            model_err = 1'b0;
        end else begin
            if (out_val && out_rdy) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL sb_pop: got ch=%0d data=%02h, required nothing pending", out_chan, out_data);
                end else begin
                    exp_r = sb_q.pop_front();
                    if ({out_chan, out_data} !== exp_r) begin
                        n_mis++;
                        $display("FAIL sb_pop: got ch=%0d data=%02h, required ch=%0d data=%02h",
                                 out_chan, out_data, exp_r.ch, exp_r.d);
                    end
                end
            end
            if (in_val && in_rdy) begin
                if (int'(in_chan) >= NUM_CH) begin
                    nv = '0;
                    model_err = 1'b1;
                end else begin
                    case (in_op)
                        2'd0:    nv = in_data;
                        2'd1:    nv = model_ctx[in_chan] + in_data;
                        2'd2:    nv = model_ctx[in_chan] ^ in_data;
                        default: nv = model_ctx[in_chan];
                    endcase
                    model_ctx[in_chan] = nv;
                end
                sb_q.push_back({in_chan, nv});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [CH_W-1:0] ch, input logic [1:0] op, input logic [DATA_W-1:0] d);
        in_val  = 1'b1;
        in_chan = ch;
        in_op   = op;
        in_data = d;
    endtask

    task automatic drain();
        in_val  = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 30 && (sb_q.size() != 0 || out_val); i++) tick();
        n_cmp++;
        if (sb_q.size() != 0 || out_val !== 1'b0) begin
            n_mis++;
            $display("FAIL drain_timeout: pending=%0d out_val=%b, required 0 and 0", sb_q.size(), out_val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_val !== 1'b0) begin n_mis++; $display("FAIL reset_out_val: got %b, required 0", out_val); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_mis++; $display("FAIL reset_fifo_cnt: got %0d, required 0", fifo_cnt); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_mis++; $display("FAIL reset_in_rdy: got %b, required 1", in_rdy); end
        n_cmp++; if (err_chan !== 1'b0) begin n_mis++; $display("FAIL reset_err_chan: got %b, required 0", err_chan); end
        n_cmp++; if ($isunknown(out_data)) begin n_mis++; $display("FAIL reset_out_data_x: got %02h, required known", out_data); end
    endtask

    task automatic test_load_basic();
        out_rdy = 1'b1;
        set_req(2'd0, 2'd0, 8'h5A);
        tick();
        in_val = 1'b0;
        n_cmp++; if (out_val !== 1'b1) begin n_mis++; $display("FAIL load_out_val: got %b, required 1", out_val); end
        n_cmp++; if (out_chan !== 2'd0) begin n_mis++; $display("FAIL load_out_chan: got %0d, required 0", out_chan); end
        n_cmp++; if (out_data !== 8'h5A) begin n_mis++; $display("FAIL load_out_data: got %02h, required 5a", out_data); end
        tick();
        n_cmp++; if (out_val !== 1'b0) begin n_mis++; $display("FAIL load_drained_val: got %b, required 0", out_val); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_mis++; $display("FAIL load_drained_cnt: got %0d, required 0", fifo_cnt); end
    endtask

    task automatic test_ops();
        logic [1:0]        ops  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [DATA_W-1:0] dats [4] = '{8'hF0, 8'h20, 8'hFF, 8'h00};
        logic [DATA_W-1:0] exps [4] = '{8'hF0, 8'h10, 8'hEF, 8'hEF};
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(2'd1, ops[i], dats[i]);
            tick();
            n_cmp++;
            if (out_data !== exps[i] || out_chan !== 2'd1) begin
                n_mis++;
                $display("FAIL ops_step%0d: got ch=%0d data=%02h, required ch=1 data=%02h", i, out_chan, out_data, exps[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(2'd2, (i == 0) ? 2'd0 : 2'd1, 8'h11);
            tick();
        end
        n_cmp++; if (fifo_cnt !== 3'd4) begin n_mis++; $display("FAIL bp_full_cnt: got %0d, required 4", fifo_cnt); end
        n_cmp++; if (in_rdy !== 1'b0) begin n_mis++; $display("FAIL bp_full_rdy: got %b, required 0", in_rdy); end
        set_req(2'd2, 2'd2, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (fifo_cnt !== 3'd4 || in_rdy !== 1'b0 || out_data !== 8'h11) begin
                n_mis++;
                $display("FAIL bp_hold%0d: got cnt=%0d rdy=%b data=%02h, required cnt=4 rdy=0 data=11",
                         i, fifo_cnt, in_rdy, out_data);
            end
        end
        out_rdy = 1'b1;
        tick();
        n_cmp++;
        if (fifo_cnt !== 3'd3 || in_rdy !== 1'b1) begin
            n_mis++;
            $display("FAIL bp_first_pop: got cnt=%0d rdy=%b, required cnt=3 rdy=1", fifo_cnt, in_rdy);
        end
        tick();
        in_val = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd3) begin n_mis++; $display("FAIL bp_push_pop: got cnt=%0d, required 3", fifo_cnt); end
        drain();
    endtask

    task automatic test_full_stream();
        int accepted;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 8'($urandom));
            tick();
        end
        out_rdy  = 1'b1;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            set_req(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 8'($urandom));
            if (in_rdy) accepted++;
            tick();
            n_cmp++;
            if (int'(fifo_cnt) != sb_q.size() || fifo_cnt < 3'd3) begin
                n_mis++;
                $display("FAIL stream_cnt%0d: got %0d, required %0d (3 or 4)", i, fifo_cnt, sb_q.size());
            end
        end
        n_cmp++;
        if (accepted < 11) begin
            n_mis++;
            $display("FAIL stream_throughput: got %0d accepts in 12 cycles, required >= 11", accepted);
        end
        drain();
    endtask

    task automatic test_bad_chan();
        logic [DATA_W-1:0] vals [3] = '{8'hA1, 8'hB2, 8'hC3};
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(2'(i), 2'd0, vals[i]);
            tick();
        end
        set_req(2'd3, 2'd1, 8'h01);
        tick();
        in_val = 1'b0;
        n_cmp++;
        if (out_data !== 8'h00 || out_chan !== 2'd3 || err_chan !== 1'b1) begin
            n_mis++;
            $display("FAIL badch_result: got ch=%0d data=%02h err=%b, required ch=3 data=00 err=1", out_chan, out_data, err_chan);
        end
        tick();
        tick();
        n_cmp++; if (err_chan !== model_err) begin n_mis++; $display("FAIL badch_sticky: got %b, required %b", err_chan, model_err); end
        for (int i = 0; i < 3; i++) begin
            set_req(2'(i), 2'd3, 8'h5C);
            tick();
            n_cmp++;
            if (out_data !== vals[i]) begin
                n_mis++;
                $display("FAIL badch_ctx%0d: got %02h, required %02h", i, out_data, vals[i]);
            end
        end
        drain();
        n_cmp++; if (err_chan !== 1'b1) begin n_mis++; $display("FAIL badch_sticky_late: got %b, required 1", err_chan); end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(2'(i), 2'd1, 8'h33);
            tick();
        end
        in_val = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd3) begin n_mis++; $display("FAIL rstmid_fill: got %0d, required 3", fifo_cnt); end
        rst = 1'b1;
        set_req(2'd0, 2'd0, 8'h77);
        tick();
        rst    = 1'b0;
        in_val = 1'b0;
        n_cmp++;
        if (out_val !== 1'b0 || fifo_cnt !== 3'd0 || err_chan !== 1'b0) begin
            n_mis++;
            $display("FAIL rstmid_state: got val=%b cnt=%0d err=%b, required 0 0 0", out_val, fifo_cnt, err_chan);
        end
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(2'(i), 2'd3, 8'hAA);
            tick();
            n_cmp++;
            if (out_data !== 8'h00) begin
                n_mis++;
                $display("FAIL rstmid_ctx%0d: got %02h, required 00", i, out_data);
            end
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_val    = 1'b0;
        in_chan   = '0;
        in_op     = '0;
        in_data   = '0;
        out_rdy   = 1'b1;
        model_err = 1'b0;
        for (int i = 0; i < NUM_CH; i++) model_ctx[i] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_basic();
        test_ops();
        test_backpressure();
        test_full_stream();
        test_bad_chan();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
